// File: rtl/sbus_mem_responder.sv
// SBUS memory-side responder: answers START with a single ACKN pulse, then streams read words
// and/or absorbs write words for the requested slots of one quadword.
// Optional build macro SBUS_PAR_INJECT_EN adds INJECT_PAR_ERR, which inverts the parity of
// read words while high (storage untouched).
module sbus_mem_responder #(
  parameter logic [21:0] BASE_ADR   = 22'o0,
  parameter int unsigned MEM_WORDS  = 4096,
  parameter int unsigned ACK_DLY    = 3,
  parameter int unsigned DV_GAP     = 1,
  parameter int unsigned WR_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        RESET,
`ifdef SBUS_PAR_INJECT_EN
  input  logic        INJECT_PAR_ERR,
`endif
  input  logic        START,
  input  logic        RD_RQ,
  input  logic        WR_RQ,
  input  logic [0:3]  RQ,
  input  logic [14:35] ADR,
  input  logic        ADR_PAR,
  input  logic [0:35] DATA_IN,
  input  logic        DATA_PAR_IN,
  input  logic        DATA_VALID_IN,
  input  logic        ERR_CLR,
  output logic [0:35] DATA_OUT,
  output logic        DATA_PAR_OUT,
  output logic        DATA_VALID_OUT,
  output logic        ACKN,
  output logic        ADR_PAR_ERR,
  output logic        MEM_ERROR,
  output logic        BUSY
);

  localparam int unsigned AW = $clog2(MEM_WORDS);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StAckWait = 3'd1;
  localparam logic [2:0] StAckn    = 3'd2;
  localparam logic [2:0] StRdXfer  = 3'd3;
  localparam logic [2:0] StWrXfer  = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [15:0]   cnt_q, cnt_d;       // ack delay, read gap or write timeout, by phase
  logic          rd_q, rd_d, wr_q, wr_d;
  logic [0:3]    rq_q, rq_d, rem_q, rem_d, rem_clr;
  logic [1:0]    slot0_q, slot0_d, cur_slot, probe;
  logic [AW-3:0] base_q, base_d;
  logic [0:35]   dout_q, dout_d;
  logic          dpar_q, dpar_d, dv_q, dv_d;
  logic          adr_err_q, adr_err_d, mem_err_q, mem_err_d;
  logic [36:0]   mem_q [MEM_WORDS];  // {data, parity as received}
  logic [AW-1:0] cur_idx;
  logic [36:0]   rd_word;
  logic [21:0]   adr_w, adr_off;
  logic          in_range, adr_par_ok, dpar_ok, inj, emit, enter_wr, mem_we;

`ifdef SBUS_PAR_INJECT_EN
  assign inj = INJECT_PAR_ERR;
`else
  assign inj = 1'b0;
`endif

  assign adr_w      = ADR;
  assign adr_off    = adr_w - BASE_ADR;
  assign in_range   = (32'(adr_off) < MEM_WORDS) && (RD_RQ || WR_RQ);
  assign adr_par_ok = ^{ADR, ADR_PAR};
  assign dpar_ok    = ^{DATA_IN, DATA_PAR_IN};
  assign cur_idx    = {base_q, cur_slot};
  assign rd_word    = mem_q[cur_idx];

  // Pick the first outstanding slot in wrap order starting at the first-word slot.
  always_comb begin
    cur_slot = slot0_q;
    probe    = '0;
    for (int k = 3; k >= 0; k--) begin
      probe = slot0_q + 2'(k);
      if (rem_q[probe]) cur_slot = probe;
    end
    rem_clr           = rem_q;
    rem_clr[cur_slot] = 1'b0;
  end

  // Next-state: request capture, ack timing, read streaming and write absorption.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    rq_d      = rq_q;
    rem_d     = rem_q;
    slot0_d   = slot0_q;
    base_d    = base_q;
    dout_d    = dout_q;
    dpar_d    = dpar_q;
    dv_d      = 1'b0;
    // A same-clock error event below overrides the clear.
    adr_err_d = adr_err_q & ~ERR_CLR;
    mem_err_d = mem_err_q & ~ERR_CLR;
    emit      = 1'b0;
    enter_wr  = 1'b0;
    mem_we    = 1'b0;

    case (state_q)
      StIdle: begin
        if (START && in_range) begin
          if (!adr_par_ok) begin
            adr_err_d = 1'b1;
          end else begin
            rd_d    = RD_RQ;
            wr_d    = WR_RQ;
            rq_d    = RQ;
            rem_d   = RQ;
            slot0_d = adr_w[1:0];
            base_d  = (AW-2)'(adr_w[21:2] - BASE_ADR[21:2]);
            cnt_d   = '0;
            state_d = (ACK_DLY > 1) ? StAckWait : StAckn;
          end
        end
      end
      StAckWait: begin
        if (cnt_q == 16'(ACK_DLY - 2)) state_d = StAckn;
        else                           cnt_d   = cnt_q + 16'd1;
      end
      StAckn: begin
        if (rd_q && (|rq_q))      emit     = 1'b1;
        else if (wr_q && (|rq_q)) enter_wr = 1'b1;
        else                      state_d  = StIdle;
      end
      StRdXfer: begin
        if (cnt_q != '0) cnt_d = cnt_q - 16'd1;
        else             emit  = 1'b1;
      end
      StWrXfer: begin
        if (DATA_VALID_IN) begin
          mem_we = 1'b1;
          rem_d  = rem_clr;
          cnt_d  = '0;
          if (!dpar_ok) mem_err_d = 1'b1;
          if (rem_clr == '0) state_d = StIdle;
        end else if (cnt_q == 16'(WR_TIMEOUT - 1)) begin
          mem_err_d = 1'b1;
          state_d   = StIdle;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (emit) begin
      dv_d    = 1'b1;
      dout_d  = rd_word[36:1];
      dpar_d  = rd_word[0] ^ inj;
      rem_d   = rem_clr;
      cnt_d   = 16'(DV_GAP);
      state_d = StRdXfer;
      if (rem_clr == '0) begin
        if (wr_q) enter_wr = 1'b1;
        else      state_d  = StIdle;
      end
    end

    // Read-pause-write reuses the same slot mask for the write phase.
    if (enter_wr) begin
      state_d = StWrXfer;
      rem_d   = rq_q;
      cnt_d   = '0;
    end
  end

  // Control and output registers; storage is deliberately outside the reset domain.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      rq_q      <= '0;
      rem_q     <= '0;
      slot0_q   <= '0;
      base_q    <= '0;
      dout_q    <= '0;
      dpar_q    <= 1'b0;
      dv_q      <= 1'b0;
      adr_err_q <= 1'b0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      rq_q      <= rq_d;
      rem_q     <= rem_d;
      slot0_q   <= slot0_d;
      base_q    <= base_d;
      dout_q    <= dout_d;
      dpar_q    <= dpar_d;
      dv_q      <= dv_d;
      adr_err_q <= adr_err_d;
      mem_err_q <= mem_err_d;
    end
  end

  // Word storage, written one slot per accepted DATA_VALID_IN.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[cur_idx] <= {DATA_IN, DATA_PAR_IN};
  end

  assign DATA_OUT       = dout_q;
  assign DATA_PAR_OUT   = dpar_q;
  assign DATA_VALID_OUT = dv_q;
  assign ACKN           = (state_q == StAckn);
  assign ADR_PAR_ERR    = adr_err_q;
  assign MEM_ERROR      = mem_err_q;
  assign BUSY           = (state_q != StIdle);

endmodule
